// File: rtl/img_pool_capture.sv
// Captures a (7*POOL)^2 greyscale raster frame and reduces it to a 7x7 binary image for predict.
// Optional build macro IMG_POOL_INVERT_EN: treat dark pixels (pix_data < PIX_THRESH) as lit.
module img_pool_capture #(
  parameter int POOL        = 4,
  parameter int PIX_W       = 8,
  parameter int PIX_THRESH  = 128,
  parameter int CELL_THRESH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_data,
  output logic             pix_ready,
  output logic             busy,
  output logic [48:0]      img,
  output logic             img_valid
);

  localparam int SIDE = 7 * POOL;
  localparam int XW   = $clog2(SIDE);
  localparam int CW   = $clog2(POOL * POOL + 1);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   x_q, x_d, y_q, y_d;
  logic [CW-1:0]   cnt_q [7];
  logic [CW-1:0]   cnt_d [7];
  logic [48:0]     img_q, img_d;

  logic [2:0]      col_w, row_w;
  logic            row_end_w, cell_row_end_w, frame_end_w;

  function automatic logic pix_lit(input logic [PIX_W-1:0] p);
`ifdef IMG_POOL_INVERT_EN
    return p < PIX_W'(PIX_THRESH);
`else
    return p >= PIX_W'(PIX_THRESH);
`endif
  endfunction

  function automatic logic cell_on(input logic [CW-1:0] n);
    return n >= CW'(CELL_THRESH);
  endfunction

  assign col_w          = 3'(x_q / XW'(POOL));
  assign row_w          = 3'(y_q / XW'(POOL));
  assign row_end_w      = (x_q == XW'(SIDE - 1));
  assign cell_row_end_w = (y_q % XW'(POOL)) == XW'(POOL - 1);
  assign frame_end_w    = (y_q == XW'(SIDE - 1));

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    img_d   = img_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_CAPTURE;
          x_d     = '0;
          y_d     = '0;
          img_d   = '0;
          for (int c = 0; c < 7; c++) cnt_d[c] = '0;
        end
      end
      S_CAPTURE: begin
        if (pix_valid) begin
          if (pix_lit(pix_data)) cnt_d[col_w] = cnt_q[col_w] + CW'(1);
          if (row_end_w) begin
            x_d = '0;
            y_d = y_q + XW'(1);
            // Commit uses the updated counts so the last pixel of the cell band is included.
            if (cell_row_end_w) begin
              for (int c = 0; c < 7; c++) begin
                img_d[int'(row_w) * 7 + c] = cell_on(cnt_d[c]);
                cnt_d[c] = '0;
              end
            end
            if (frame_end_w) begin
              y_d     = '0;
              state_d = S_DONE;
            end
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      img_q   <= '0;
      for (int c = 0; c < 7; c++) cnt_q[c] <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      img_q   <= img_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pix_ready = (state_q == S_CAPTURE);
  assign busy      = (state_q == S_CAPTURE);
  assign img_valid = (state_q == S_DONE);
  assign img       = img_q;

endmodule

// File: tb/tb_img_pool_capture.sv
// Scoreboard bench for img_pool_capture: expected images queued per frame, popped at completion.
module tb_img_pool_capture;

  logic        clk = 1'b0;
  logic        reset, start, pix_valid;
  logic [7:0]  pix_data;
  logic        pix_ready, busy, img_valid;
  logic [48:0] img;

  int total = 0;
  int bad   = 0;
  logic [7:0]  frame [784];
  logic [48:0] exp_q [$];

  always #5 clk = ~clk;

  img_pool_capture dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .pix_ready (pix_ready),
    .busy      (busy),
    .img       (img),
    .img_valid (img_valid)
  );

  function automatic logic lit_ref(input logic [7:0] p);
`ifdef IMG_POOL_INVERT_EN
    return p < 8'd128;
`else
    return p >= 8'd128;
`endif
  endfunction

  function automatic logic [48:0] model_img();
    logic [48:0] m;
    m = '0;
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++) begin
        int n;
        n = 0;
        for (int dy = 0; dy < 4; dy++)
          for (int dx = 0; dx < 4; dx++)
            if (lit_ref(frame[(r * 4 + dy) * 28 + c * 4 + dx])) n++;
        m[r * 7 + c] = (n >= 4);
      end
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 784; i++) frame[i] = v;
  endtask

  task automatic do_frame(input bit gaps, input bit pulses, output logic [48:0] got);
    int idx, cyc;
    bit acc;
    logic [48:0] exp;
    idx = 0;
    cyc = 0;
    exp_q.push_back(model_img());
    start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || img !== 49'h0 || img_valid !== 1'b0) begin
      bad++;
      $display("FAIL frame_start: busy=%b img_valid=%b img=%h, want 1 0 0", busy, img_valid, img);
    end
    while (idx < 784 && cyc < 784 * 8) begin
      pix_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      pix_data  = pix_valid ? frame[idx] : 8'($urandom);
      start     = pulses ? 1'($urandom_range(0, 1)) : 1'b0;
      acc       = pix_valid & pix_ready;
      tick();
      cyc++;
      if (acc) idx++;
      if (gaps && idx < 784) begin
        total++;
        if (busy !== 1'b1 || img_valid !== 1'b0) begin
          bad++;
          $display("FAIL busy_hold: busy=%b img_valid=%b at pixel %0d, want 1 0", busy, img_valid, idx);
        end
      end
    end
    pix_valid = 1'b0;
    start     = 1'b0;
    if (idx < 784) begin
      total++;
      bad++;
      $display("FAIL timeout: accepted %0d pixels, want 784", idx);
    end
    exp = exp_q.pop_front();
    total++;
    if (img_valid !== 1'b1 || pix_ready !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL done_latency: img_valid=%b pix_ready=%b busy=%b, want 1 0 0", img_valid, pix_ready, busy);
    end
    total++;
    if (img !== exp) begin
      bad++;
      $display("FAIL img: got %h want %h", img, exp);
    end
    got = img;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_data = 8'h0;
    tick(); tick();
    reset = 1'b0;
    tick();
    total++;
    if (img !== 49'h0 || img_valid !== 1'b0 || busy !== 1'b0 || pix_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset: img=%h img_valid=%b busy=%b pix_ready=%b, want all 0", img, img_valid, busy, pix_ready);
    end
    // pixels offered in IDLE must not start anything
    pix_valid = 1'b1; pix_data = 8'hFF;
    repeat (5) tick();
    pix_valid = 1'b0;
    total++;
    if (busy !== 1'b0 || img !== 49'h0 || img_valid !== 1'b0) begin
      bad++;
      $display("FAIL idle_ignore: busy=%b img=%h img_valid=%b, want 0 0 0", busy, img, img_valid);
    end
  endtask

  task automatic test_zeros();
    logic [48:0] got, want;
`ifdef IMG_POOL_INVERT_EN
    want = {49{1'b1}};
`else
    want = 49'h0;
`endif
    fill(8'd0);
    do_frame(1'b0, 1'b0, got);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL zeros_const: got %h want %h", got, want);
    end
  endtask

  task automatic test_ones();
    logic [48:0] got, want;
`ifdef IMG_POOL_INVERT_EN
    want = 49'h0;
`else
    want = 49'h1_FFFF_FFFF_FFFF;
`endif
    fill(8'd255);
    do_frame(1'b0, 1'b0, got);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL ones_const: got %h want %h", got, want);
    end
    // DONE holds the image while pixels keep arriving
    pix_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pix_data = 8'($urandom);
      tick();
      total++;
      if (img !== want || img_valid !== 1'b1 || pix_ready !== 1'b0) begin
        bad++;
        $display("FAIL done_hold: img=%h img_valid=%b pix_ready=%b, want %h 1 0", img, img_valid, pix_ready, want);
      end
    end
    pix_valid = 1'b0;
  endtask

  task automatic test_cell_thresh();
    logic [48:0] got;
    fill(8'd0);
    frame[0] = 8'd200; frame[1] = 8'd200; frame[28] = 8'd200;
    do_frame(1'b0, 1'b0, got);
`ifndef IMG_POOL_INVERT_EN
    total++;
    if (got !== 49'h0) begin
      bad++;
      $display("FAIL cell_three: got %h want 0", got);
    end
`endif
    frame[87] = 8'd200;  // still in cell (0,0): y=3, x=3
    do_frame(1'b0, 1'b0, got);
`ifndef IMG_POOL_INVERT_EN
    total++;
    if (got !== 49'h1) begin
      bad++;
      $display("FAIL cell_four: got %h want 1", got);
    end
`endif
  endtask

  task automatic test_column();
    logic [48:0] got, want;
    fill(8'd0);
    for (int y = 0; y < 28; y++)
      for (int x = 12; x < 16; x++) frame[y * 28 + x] = 8'd255;
    want = '0;
    for (int r = 0; r < 7; r++) want[r * 7 + 3] = 1'b1;
`ifdef IMG_POOL_INVERT_EN
    want = ~want;
`endif
    do_frame(1'b0, 1'b0, got);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL column3: got %h want %h", got, want);
    end
  endtask

  task automatic test_back_to_back_gaps();
    logic [48:0] a, b;
    for (int i = 0; i < 784; i++) frame[i] = ($urandom_range(0, 3) == 0) ? 8'd200 : 8'd40;
    do_frame(1'b0, 1'b0, a);
    do_frame(1'b1, 1'b1, b);
    total++;
    if (a !== b) begin
      bad++;
      $display("FAIL gap_equiv: gapped %h gap-free %h", b, a);
    end
  endtask

  task automatic test_mid_reset();
    logic [48:0] got;
    int idx;
    idx = 0;
    fill(8'd255);
    start = 1'b1;
    tick();
    start = 1'b0;
    pix_valid = 1'b1;
    pix_data  = 8'd255;
    while (idx < 300) begin
      tick();
      idx++;
    end
    pix_valid = 1'b0;
    total++;
    if (busy !== 1'b1 || img === 49'h0) begin
      bad++;
      $display("FAIL partial: busy=%b img=%h, want busy 1 with rows committed", busy, img);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (img !== 49'h0 || img_valid !== 1'b0 || busy !== 1'b0 || pix_ready !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: img=%h img_valid=%b busy=%b pix_ready=%b, want all 0", img, img_valid, busy, pix_ready);
    end
    do_frame(1'b0, 1'b0, got);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_data = 8'h0;
    test_reset();
    test_zeros();
    test_ones();
    test_cell_thresh();
    test_column();
    test_back_to_back_gaps();
    test_mid_reset();
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_left: %0d entries, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
